voice_mix_pwm: RTL and testbench

//  Downstream audio output stage. Mixes the signed 8-bit sound_wave outputs of up to NUM_VOICES

---
 rtl/audio_pkg.sv | 23 ++
 rtl/voice_mix_pwm_pwm_core.sv | 43 ++++
 rtl/voice_mix_pwm.sv | 125 ++++++++++++
 tb/tb_voice_mix_pwm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio output stages: mixer FSM states,
// midscale duty and accumulator sizing helpers.
package audio_pkg;

  localparam int DEFAULT_PWM_W = 8;
  localparam int MIDSCALE      = 2 ** (DEFAULT_PWM_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } mix_state_t;

  // Signed accumulator wide enough that summing num_voices samples cannot overflow.
  function automatic int acc_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices) + 1;
  endfunction

  function automatic int midscale(input int pwm_w);
    return 2 ** (pwm_w - 1);
  endfunction

endpackage

// File: rtl/voice_mix_pwm_pwm_core.sv
// PWM engine: free-running period counter, double-buffered duty/clip and the
// registered comparator driving the audio pin.
module pwm_core
  import audio_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mute,
  input  logic [PWM_W-1:0] duty_next,
  input  logic             clip_next,
  output logic [PWM_W-1:0] cnt,
  output logic             aud_pwm,
  output logic             sample_tick,
  output logic             clip
);

  localparam logic [PWM_W-1:0] CNT_MAX  = '1;
  localparam logic [PWM_W-1:0] MID_DUTY = PWM_W'(midscale(PWM_W));

  logic [PWM_W-1:0] duty_active;

  // Duty and clip only change at the period boundary, so a period never mixes two samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      duty_active <= MID_DUTY;
      aud_pwm     <= 1'b0;
      sample_tick <= 1'b0;
      clip        <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      sample_tick <= (cnt == CNT_MAX);
      aud_pwm     <= ~mute & (cnt < duty_active);
      if (cnt == CNT_MAX) begin
        duty_active <= duty_next;
        clip        <= clip_next;
      end
    end
  end

endmodule

// File: rtl/voice_mix_pwm.sv
// Mono audio output stage: serially mixes the voice samples once per PWM
// period, saturates the sum and hands the resulting duty to pwm_core.
module voice_mix_pwm
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8,
  parameter int PWM_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
  input  logic [NUM_VOICES-1:0]          voice_on,
  input  logic                           mute,
  output logic                           aud_pwm,
  output logic                           aud_sd,
  output logic                           sample_tick,
  output logic                           clip
);

  localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0]    ACC_MAX  = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [ACC_W-1:0]    ACC_MIN  = ACC_W'(-(2 ** (SAMPLE_W - 1)));
  localparam logic signed [SAMPLE_W-1:0] S_MAX    = SAMPLE_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [SAMPLE_W-1:0] S_MIN    = SAMPLE_W'(-(2 ** (SAMPLE_W - 1)));
  localparam logic [PWM_W-1:0]           MID_DUTY = PWM_W'(midscale(PWM_W));

  mix_state_t                     state;
  logic [IDX_W-1:0]               idx;
  logic signed [ACC_W-1:0]        acc;
  logic [NUM_VOICES*SAMPLE_W-1:0] shadow_voice;
  logic [NUM_VOICES-1:0]          shadow_on;
  logic [PWM_W-1:0]               duty_next;
  logic                           clip_next;
  logic [PWM_W-1:0]               cnt;

  logic signed [SAMPLE_W-1:0]     cur_sample;
  logic signed [SAMPLE_W-1:0]     clamped;
  logic                           sat;
  logic [SAMPLE_W-1:0]            offset;
  logic [PWM_W-1:0]               scaled;

  assign cur_sample = shadow_on[idx] ? shadow_voice[idx*SAMPLE_W +: SAMPLE_W] : '0;

  always_comb begin
    sat     = 1'b0;
    clamped = acc[SAMPLE_W-1:0];
    if (acc > ACC_MAX) begin
      clamped = S_MAX;
      sat     = 1'b1;
    end else if (acc < ACC_MIN) begin
      clamped = S_MIN;
      sat     = 1'b1;
    end
  end

  // Adding half-scale to a two's complement value is just flipping its sign bit.
  assign offset = {~clamped[SAMPLE_W-1], clamped[SAMPLE_W-2:0]};
  assign scaled = PWM_W'(offset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      shadow_voice <= '0;
      shadow_on    <= '0;
      duty_next    <= MID_DUTY;
      clip_next    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt == '0) begin
            shadow_voice <= voice_in;
            shadow_on    <= voice_on;
            acc          <= '0;
            idx          <= '0;
            state        <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(cur_sample);
          if (idx == LAST_IDX) begin
            state <= SCALE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SCALE: begin
          duty_next <= scaled;
          clip_next <= sat;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Amplifier enable deliberately ignores the counter so mute acts on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aud_sd <= 1'b0;
    end else begin
      aud_sd <= ~mute;
    end
  end

  pwm_core #(
    .PWM_W (PWM_W)
  ) u_pwm_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .mute        (mute),
    .duty_next   (duty_next),
    .clip_next   (clip_next),
    .cnt         (cnt),
    .aud_pwm     (aud_pwm),
    .sample_tick (sample_tick),
    .clip        (clip)
  );

endmodule

// File: tb/tb_voice_mix_pwm.sv
// Bench for voice_mix_pwm: period-level model of duty/clip per PWM period,
// per-cycle output comparison and directed literal checks.
module tb_voice_mix_pwm;

  localparam int NV     = 4;
  localparam int SW     = 8;
  localparam int PW     = 8;
  localparam int PERIOD = 256;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0]    v [NV];
  logic [NV-1:0]    on;
  logic             mute;
  logic [NV*SW-1:0] voice_in;
  logic             aud_pwm, aud_sd, sample_tick, clip;

  assign voice_in = {v[3], v[2], v[1], v[0]};

  voice_mix_pwm #(
    .NUM_VOICES (NV),
    .SAMPLE_W   (SW),
    .PWM_W      (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .voice_in    (voice_in),
    .voice_on    (on),
    .mute        (mute),
    .aud_pwm     (aud_pwm),
    .aud_sd      (aud_sd),
    .sample_tick (sample_tick),
    .clip        (clip)
  );

  int n_checks   = 0;
  int n_errors   = 0;
  int edge_count = 0;

  // model state indexed by period number since the last reset release
  int duty_tab [int];
  bit clip_tab [int];
  int period_high [int];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Period mix from the rules: sum enabled signed voices, saturate, offset by half scale.
  function automatic void model_mix(output int duty, output bit clp);
    int s;
    s = 0;
    for (int i = 0; i < NV; i++) begin
      if (on[i]) s += int'($signed(v[i]));
    end
    clp = (s > 127) || (s < -128);
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    duty = s + 128;
  endfunction

  // scoreboard: compare every cycle against the period model
  initial begin
    int  c, d;
    bit  cl, m;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edge_count = 0;
        duty_tab.delete();
        clip_tab.delete();
        period_high.delete();
        duty_tab[0] = 128;
        clip_tab[0] = 1'b0;
        #1;
        chk("rst_aud_pwm", int'(aud_pwm), 0);
        chk("rst_aud_sd", int'(aud_sd), 0);
        chk("rst_sample_tick", int'(sample_tick), 0);
        chk("rst_clip", int'(clip), 0);
      end else begin
        c = edge_count;
        edge_count++;
        m = mute;
        if (c % PERIOD == 0) begin
          model_mix(d, cl);
          duty_tab[c / PERIOD + 1] = d;
          clip_tab[c / PERIOD + 1] = cl;
          period_high[c / PERIOD]  = 0;
        end
        #1;
        chk("aud_pwm", int'(aud_pwm), (!m && ((c % PERIOD) < duty_tab[c / PERIOD])) ? 1 : 0);
        chk("aud_sd", int'(aud_sd), m ? 0 : 1);
        chk("sample_tick", int'(sample_tick), (c % PERIOD == PERIOD - 1) ? 1 : 0);
        chk("clip", int'(clip), int'(clip_tab[(c + 1) / PERIOD]));
        if (aud_pwm) period_high[c / PERIOD]++;
      end
    end
  end

  task automatic wait_to(input int n);
    while (edge_count < n) @(negedge clk);
  endtask

  task automatic count_to_tick(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!sample_tick && k < 600);
  endtask

  // driver with directed literal expectations
  initial begin
    int k;
    v    = '{default: 8'd0};
    on   = '0;
    mute = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wait_to(100);  v[0] = 8'd64; on = 4'b0001;
    wait_to(256);  chk("p0_high", period_high[0], 128);
    wait_to(300);  v = '{default: 8'd64}; on = 4'b1111;
    wait_to(512);  chk("p1_high", period_high[1], 128);
    wait_to(600);  chk("p2_clip", int'(clip), 0); v = '{default: 8'hC0};
    wait_to(768);  chk("p2_high", period_high[2], 192);
    wait_to(900);  chk("p3_clip", int'(clip), 1);
                   v = '{default: 8'd0}; on = 4'b0001;
    wait_to(1024); chk("p3_high", period_high[3], 255);
    wait_to(1100); chk("p4_clip", int'(clip), 1);
    wait_to(1280); chk("p4_high", period_high[4], 0);
    wait_to(1290); v[0] = 8'd100;
    wait_to(1536); chk("p5_high", period_high[5], 128);
    wait_to(1792); chk("p6_high", period_high[6], 128);
    wait_to(2000); v = '{default: 8'd127}; on = 4'b1111;
    wait_to(2048); chk("p7_high", period_high[7], 228);

    wait_to(2068);
    mute = 1'b1;
    @(posedge clk);
    #1;
    chk("mute_aud_sd", int'(aud_sd), 0);
    chk("mute_aud_pwm", int'(aud_pwm), 0);
    wait_to(2368);
    mute = 1'b0;
    count_to_tick(k);
    chk("tick_after_unmute", int'(sample_tick), 1);
    count_to_tick(k);
    chk("tick_spacing", k, 256);

    wait_to(11 * PERIOD + 77);
    chk("pre_rst_aud_pwm", int'(aud_pwm), 1);
    chk("pre_rst_clip", int'(clip), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_aud_pwm", int'(aud_pwm), 0);
    chk("async_rst_aud_sd", int'(aud_sd), 0);
    chk("async_rst_clip", int'(clip), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_to_tick(k);
    chk("first_tick_after_rst", k, 256);
    @(negedge clk);
    chk("rst_p0_high", period_high[0], 128);
    wait_to(512);
    chk("rst_p1_high", period_high[1], 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
